// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM states, width helpers and saturation for the convolution MAC engine.
package conv_pkg;

   typedef enum logic [1:0] {IDLE, MAC, QUANT, OUT} state_e;

   function automatic int tap_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

   function automatic int acc_w(input int dw, input int n);
      return 2 * dw + $clog2(n);
   endfunction

   // Clamp a wide signed value to the range of an ow-bit signed result.
   function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int ow);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 1));
      return v > hi ? hi : v < lo ? lo : v;
   endfunction

endpackage

// File: rtl/conv_requant.sv
// conv_requant: arithmetic shift, optional ReLU (CONV_RELU_EN) and saturation of the accumulator.
module conv_requant
   import conv_pkg::*;
#(
   parameter int ACC_WIDTH = 19,
   parameter int OUT_WIDTH = 8,
   parameter int SHIFT     = 0
) (
   input  logic signed [ACC_WIDTH-1:0] acc_i,
   output logic signed [OUT_WIDTH-1:0] q_o
);

   logic signed [63:0] ext, sh, rl, st;

   always_comb begin
      ext = 64'(acc_i);
      sh  = ext >>> SHIFT;
`ifdef CONV_RELU_EN
      rl  = sh < 0 ? 64'sd0 : sh;
`else
      rl  = sh;
`endif
      st  = sat(rl, OUT_WIDTH);
      q_o = OUT_WIDTH'(st);
   end

endmodule

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: KSIZE x KSIZE window convolution, one tap per cycle through a single MAC.
// Requantisation honours CONV_RELU_EN (see conv_requant).
module conv_mac_engine
   import conv_pkg::*;
#(
   parameter int KSIZE      = 3,
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = 8,
   parameter int SHIFT      = 0
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     ena_i,
   input  logic                                     k_we_i,
   input  logic [tap_w(KSIZE*KSIZE)-1:0]            k_addr_i,
   input  logic [DATA_WIDTH-1:0]                    k_wdata_i,
   input  logic                                     in_valid_i,
   output logic                                     in_ready_o,
   input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]        in_window_i,
   output logic                                     out_valid_o,
   input  logic                                     out_ready_i,
   output logic [OUT_WIDTH-1:0]                     out_data_o
);

   localparam int N         = KSIZE * KSIZE;
   localparam int AW        = tap_w(N);
   localparam int ACC_WIDTH = acc_w(DATA_WIDTH, N);

   state_e                              state_q, state_d;
   logic [AW-1:0]                       tap_q, tap_d;
   logic signed [ACC_WIDTH-1:0]         acc_q, acc_d;
   logic [N-1:0][DATA_WIDTH-1:0]        win_q, win_d, kern_q, kern_d;
   logic                                ov_q, ov_d;
   logic [OUT_WIDTH-1:0]                od_q, od_d;
   logic signed [2*DATA_WIDTH-1:0]      prod;
   logic signed [OUT_WIDTH-1:0]         q;

   assign prod        = $signed(win_q[tap_q]) * $signed(kern_q[tap_q]);
   assign in_ready_o  = state_q == IDLE && ena_i;
   assign out_valid_o = ov_q;
   assign out_data_o  = od_q;

   conv_requant #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)) u_requant (
      .acc_i (acc_q),
      .q_o   (q)
   );

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      acc_d   = acc_q;
      win_d   = win_q;
      kern_d  = kern_q;
      ov_d    = ov_q;
      od_d    = od_q;
      if (ena_i) begin
         // A same-cycle weight write lands before the MAC phase reads it.
         if (state_q == IDLE && k_we_i && 32'(k_addr_i) < N)
            kern_d[k_addr_i] = k_wdata_i;
         case (state_q)
            IDLE: if (in_valid_i) begin
               win_d   = in_window_i;
               acc_d   = '0;
               tap_d   = '0;
               state_d = MAC;
            end
            MAC: begin
               acc_d   = acc_q + ACC_WIDTH'(prod);
               tap_d   = tap_q + AW'(1);
               state_d = tap_q == AW'(N - 1) ? QUANT : MAC;
            end
            QUANT: begin
               od_d    = q;
               ov_d    = 1'b1;
               state_d = OUT;
            end
            default: if (out_ready_i) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         tap_q   <= '0;
         acc_q   <= '0;
         win_q   <= '0;
         kern_q  <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         acc_q   <= acc_d;
         win_q   <= win_d;
         kern_q  <= kern_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
      end
   end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: directed and random stimulus against a sum-of-products reference,
// with two engines (SHIFT 0 and SHIFT 1) sharing every input.
module tb_conv_mac_engine;

   localparam int N = 9;

   logic        clk = 1'b0, rst = 1'b1, ena = 1'b1, k_we = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0]  k_addr = '0;
   logic [7:0]  k_wdata = '0;
   logic [71:0] in_window = '0;
   logic        in_ready0, in_ready1, out_valid0, out_valid1;
   logic [7:0]  out_data0, out_data1;
   int          nchk = 0, errors = 0;

   always #5 clk = ~clk;

   conv_mac_engine #(.SHIFT(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .ena_i(ena), .k_we_i(k_we), .k_addr_i(k_addr),
      .k_wdata_i(k_wdata), .in_valid_i(in_valid), .in_ready_o(in_ready0),
      .in_window_i(in_window), .out_valid_o(out_valid0), .out_ready_i(out_ready),
      .out_data_o(out_data0)
   );

   conv_mac_engine #(.SHIFT(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .ena_i(ena), .k_we_i(k_we), .k_addr_i(k_addr),
      .k_wdata_i(k_wdata), .in_valid_i(in_valid), .in_ready_o(in_ready1),
      .in_window_i(in_window), .out_valid_o(out_valid1), .out_ready_i(out_ready),
      .out_data_o(out_data1)
   );

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int req(input int s, input int sh);
      int v;
      v = s >>> sh;
`ifdef CONV_RELU_EN
      if (v < 0) v = 0;
`endif
      return v > 127 ? 127 : v < -128 ? -128 : v;
   endfunction

   function automatic logic [71:0] fill(input int v);
      logic [71:0] w;
      for (int t = 0; t < N; t++) w[t*8 +: 8] = 8'(v);
      return w;
   endfunction

   // Reference: busy from accept until the output handshake; result ready N+1 enabled edges after accept.
   int mk[N];
   int q0[$], q1[$];
   bit busy;
   int cnt;

   always @(posedge clk or posedge rst) begin
      int s;
      if (rst) begin
         foreach (mk[i]) mk[i] = 0;
         q0.delete();
         q1.delete();
         busy = 1'b0;
         cnt  = 0;
      end else if (ena) begin
         if (!busy) begin
            if (k_we && k_addr < N) mk[k_addr] = $signed(k_wdata);
            if (in_valid) begin
               s = 0;
               for (int t = 0; t < N; t++) s += $signed(in_window[t*8 +: 8]) * mk[t];
               q0.push_back(req(s, 0));
               q1.push_back(req(s, 1));
               busy = 1'b1;
               cnt  = 0;
            end
         end else if (cnt >= N + 1 && out_ready) begin
            busy = 1'b0;
            void'(q0.pop_front());
            void'(q1.pop_front());
         end else begin
            cnt++;
         end
      end
   end

   always @(negedge clk) begin
      bit ev;
      ev = busy && cnt >= N + 1;
      chk("in_ready0", int'(in_ready0), int'(!busy && ena));
      chk("in_ready1", int'(in_ready1), int'(!busy && ena));
      chk("out_valid0", int'(out_valid0), int'(ev));
      chk("out_valid1", int'(out_valid1), int'(ev));
      if (ev && q0.size() > 0) begin
         chk("out_data0", int'($signed(out_data0)), q0[0]);
         chk("out_data1", int'($signed(out_data1)), q1[0]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_k(input int addr, input int w);
      k_we    = 1'b1;
      k_addr  = 4'(addr);
      k_wdata = 8'(w);
      tick();
      k_we    = 1'b0;
   endtask

   task automatic run(input logic [71:0] w, input int gap, output int lat, output int d0, output int d1);
      int n;
      in_window = w;
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready0 && n < 50) begin
         tick();
         n++;
      end
      tick();
      in_valid  = 1'b0;
      in_window = 72'({$urandom, $urandom, $urandom});
      lat = 0;
      while (!out_valid0 && lat < 100) begin
         if (lat == 3 && gap > 0) begin
            ena = 1'b0;
            repeat (gap) begin
               tick();
               lat++;
            end
            ena = 1'b1;
         end else begin
            tick();
            lat++;
         end
      end
      chk("result_arrived", int'(out_valid0), 1);
      d0 = $signed(out_data0);
      d1 = $signed(out_data1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int lat, d0, d1, r0, r1, n;
      logic [71:0] w;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_out_valid", int'(out_valid0), 0);
      chk("reset_in_ready", int'(in_ready0), 1);
      chk("reset_out_data", int'(out_data0), 0);

      set_k(4, 1);
      w = 72'({$urandom, $urandom, $urandom});
      w[4*8 +: 8] = 8'd37;
      run(w, 0, lat, d0, d1);
      chk("identity_latency", lat, 10);
      chk("identity_data", d0, 37);
      chk("identity_shift1", d1, 18);

      for (int t = 0; t < N; t++) set_k(t, 1);
      run(fill(127), 0, lat, d0, d1);
`ifdef CONV_RELU_EN
      chk("sat_pos", d0, 127);
      run(fill(-128), 0, lat, d0, d1);
      chk("sat_neg", d0, 0);
      run(fill(-2), 0, lat, d0, d1);
      chk("neg2_shift0", d0, 0);
      chk("neg2_shift1", d1, 0);
`else
      chk("sat_pos", d0, 127);
      run(fill(-128), 0, lat, d0, d1);
      chk("sat_neg", d0, -128);
      run(fill(-2), 0, lat, d0, d1);
      chk("neg2_shift0", d0, -18);
      chk("neg2_shift1", d1, -9);
`endif

      in_window = fill(1);
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      tick();
      set_k(0, 50);
      n = 0;
      while (!out_valid0 && n < 100) begin
         tick();
         n++;
      end
      repeat (5) begin
         chk("hold_data", int'($signed(out_data0)), 9);
         chk("hold_in_ready", int'(in_ready0), 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      run(fill(1), 0, lat, d0, d1);
      chk("kernel_kept", d0, 9);

      w = 72'({$urandom, $urandom, $urandom});
      for (int t = 0; t < N; t++) set_k(t, $urandom_range(0, 6) - 3);
      run(w, 0, lat, r0, r1);
      run(w, 3, lat, d0, d1);
      chk("ena_gap_latency", lat, 13);
      chk("ena_gap_data", d0, r0);

      in_window = fill(3);
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", int'(out_valid0), 0);
      chk("midrst_in_ready", int'(in_ready0), 1);
      tick();
      rst = 1'b0;
      run(fill(5), 0, lat, d0, d1);
      chk("kernel_cleared", d0, 0);

      for (int c = 0; c < 3000; c++) begin
         ena       = $urandom_range(0, 7) != 0;
         in_valid  = $urandom_range(0, 1) == 1;
         out_ready = $urandom_range(0, 2) != 0;
         k_we      = $urandom_range(0, 3) == 0;
         k_addr    = 4'($urandom);
         k_wdata   = $urandom_range(0, 1) == 1 ? 8'($urandom) : 8'(int'($urandom_range(0, 8)) - 4);
         in_window = 72'({$urandom, $urandom, $urandom});
         rst       = $urandom_range(0, 499) == 0;
         tick();
      end
      rst       = 1'b0;
      ena       = 1'b1;
      in_valid  = 1'b0;
      k_we      = 1'b0;
      out_ready = 1'b1;
      repeat (20) tick();

      $display("Result: errors=%0d of %0d checks", errors, nchk);
      $finish;
   end

endmodule

// File: doc/conv_mac_engine.md
# conv_mac_engine

Parametrised, sequential successor to the fixed 3x3 combinational convolution cell. Accepts one KSIZE x KSIZE signed input window per valid/ready handshake and multiply-accumulates it against a run-time-loadable signed kernel, one tap per cycle, through a single MAC. The full-precision result is requantised by an arithmetic right shift and saturation, then presented on a valid/ready output port. The engine sits between the line-buffer/window generator and the pooling/activation stage of the ConvNet datapath.

## Interface
- KSIZE, 3: kernel edge; N = KSIZE*KSIZE taps.
- DATA_WIDTH, 8: signed width of window pixels and kernel weights.
- OUT_WIDTH, 8: signed output width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- ACC_WIDTH (localparam): 2*DATA_WIDTH + $clog2(N).
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ena  in  1  global enable; low freezes FSM, tap counter, accumulator and kernel writes.
- k_we  in  1  kernel write strobe.
- k_addr  in  $clog2(N)  tap index, row-major (row*KSIZE+col).
- k_wdata  in  DATA_WIDTH  signed weight.
- in_valid  in  1  window valid.
- in_ready  out  1  engine can accept a window.
- in_window  in  DATA_WIDTH x [KSIZE][KSIZE]  signed pixels.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_WIDTH  signed requantised result.

## Operation
- FSM states: IDLE, MAC, QUANT, OUT. Reset: IDLE, tap=0, acc=0, kernel all 0, out_valid=0, out_data=0, in_ready=1.
- in_ready = (state==IDLE) && ena.
- IDLE: on in_valid && in_ready, latch in_window into an internal register, clear acc, tap=0, go MAC.
- MAC: acc += sext(win[tap]) * sext(kernel[tap]); tap++; after tap N-1 is accumulated, go QUANT.
- QUANT: out_data <= sat(acc >>> SHIFT); out_valid <= 1; go OUT.
- OUT: out_data and out_valid held stable until out_ready; on out_valid && out_ready, out_valid <= 0, go IDLE.
- Saturation: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. The accumulator never overflows by construction.
- Kernel write: k_we && ena && state==IDLE && k_addr<N writes kernel[k_addr]. A write in any other state, or with k_addr>=N, is ignored.
- Kernel write and window accept in the same IDLE cycle: both take effect; the new weight is used by that window.
- ena low in any state: no state, tap, acc, kernel or output change. out_valid stays asserted if already set. An out handshake while ena is low is not taken.
- Reset mid-operation: immediate return to reset values. The kernel is cleared and the in-flight window is dropped.

## Timing
- Accept at edge E0. MAC edges E1..EN. QUANT edge EN+1. out_valid is visible from edge EN+1, so latency is N+1 cycles (10 for KSIZE=3).
- With out_ready held high and ena high: the output handshake completes at EN+2, IDLE is restored, and the next accept happens at EN+3. Minimum initiation interval is N+3 cycles.
- in_window need only be stable in the accept cycle.
- No combinational path from in_valid or out_ready to any output.

## Configuration
- CONV_RELU_EN defined: after the shift, negative values are forced to 0 before saturation, so out_data is never negative.
- CONV_RELU_EN undefined: signed result passes straight to saturation.

## Structure
- conv_pkg: state enum (IDLE, MAC, QUANT, OUT); ACC_WIDTH and tap-index width helper functions; saturation function.
- Sub-module conv_requant: combinational shift, optional ReLU and saturation from ACC_WIDTH to OUT_WIDTH, instantiated once and registered in QUANT.

## Test plan
- Identity kernel (centre=1, rest 0), window centre=37, SHIFT=0 -> out_data=37, out_valid rising exactly 10 cycles after accept.
- All weights 1, all pixels 127, SHIFT=0 -> acc=1143 -> out_data=127 (positive saturation). All pixels -128 -> out_data=-128.
- All weights 1, all pixels -2, SHIFT=1 -> -9. With CONV_RELU_EN -> 0.
- out_ready held low for 5 cycles after out_valid -> out_data stable and in_ready=0 throughout. A k_we to tap 0 during MAC leaves the kernel unchanged on the following window.
- ena dropped for 3 cycles mid-MAC -> result identical to the uninterrupted run and arrives 3 cycles later.
- reset pulsed during MAC -> out_valid=0, in_ready=1 the next cycle, kernel reads back as 0 (subsequent window gives out_data=0).
